// File: rtl/decode_stage.sv
// Decode stage of a five-stage Y86-64 pipeline.
// Holds the 15-entry register file, computes source/destination register IDs,
// forwards operands from later stages and loads the execute pipeline register.
module decode_stage (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  D_icode,
    input  logic [3:0]  D_ifun,
    input  logic [3:0]  D_stat,
    input  logic [3:0]  D_rA,
    input  logic [3:0]  D_rB,
    input  logic [63:0] D_valC,
    input  logic [63:0] D_valP,
    input  logic [3:0]  e_dstE,
    input  logic [63:0] e_valE,
    input  logic [3:0]  M_dstM,
    input  logic [63:0] m_valM,
    input  logic [3:0]  M_dstE,
    input  logic [63:0] M_valE,
    input  logic [3:0]  W_dstM,
    input  logic [63:0] W_valM,
    input  logic [3:0]  W_dstE,
    input  logic [63:0] W_valE,
    input  logic        E_bubble,
    output logic [3:0]  d_srcA,
    output logic [3:0]  d_srcB,
    output logic [3:0]  E_icode,
    output logic [3:0]  E_ifun,
    output logic [3:0]  E_stat,
    output logic [63:0] E_valC,
    output logic [63:0] E_valA,
    output logic [63:0] E_valB,
    output logic [3:0]  E_dstE,
    output logic [3:0]  E_dstM
);

    localparam logic [3:0] REG_NONE = 4'hF;
    localparam logic [3:0] REG_RSP  = 4'h4;
    localparam logic [3:0] STAT_AOK = 4'h1;
    localparam logic [3:0] I_NOP    = 4'h1;

    // Register file: indices 0..14; index F means "no register".
    logic [63:0] r_regs [0:14];

    logic [3:0]  w_srcA;
    logic [3:0]  w_srcB;
    logic [3:0]  w_dstE;
    logic [3:0]  w_dstM;
    logic [63:0] w_rf_a;
    logic [63:0] w_rf_b;
    logic [63:0] w_fwd_a;
    logic [63:0] w_fwd_b;
    logic [63:0] w_valA;

    // Source and destination register selection from the instruction code.
    always_comb begin
        w_srcA = REG_NONE;
        w_srcB = REG_NONE;
        w_dstE = REG_NONE;
        w_dstM = REG_NONE;
        case (D_icode)
            4'h2, 4'h4, 4'h6, 4'hA: w_srcA = D_rA;
            4'h9, 4'hB:             w_srcA = REG_RSP;
            default:                w_srcA = REG_NONE;
        endcase
        case (D_icode)
            4'h4, 4'h5, 4'h6:       w_srcB = D_rB;
            4'h8, 4'h9, 4'hA, 4'hB: w_srcB = REG_RSP;
            default:                w_srcB = REG_NONE;
        endcase
        case (D_icode)
            4'h2, 4'h3, 4'h6:       w_dstE = D_rB;
            4'h8, 4'h9, 4'hA, 4'hB: w_dstE = REG_RSP;
            default:                w_dstE = REG_NONE;
        endcase
        case (D_icode)
            4'h5, 4'hB:             w_dstM = D_rA;
            default:                w_dstM = REG_NONE;
        endcase
    end

    assign d_srcA = w_srcA;
    assign d_srcB = w_srcB;

    // Combinational register-file reads; the "none" index reads as zero.
    always_comb begin
        w_rf_a = 64'd0;
        w_rf_b = 64'd0;
        if (w_srcA != REG_NONE) w_rf_a = r_regs[w_srcA];
        if (w_srcB != REG_NONE) w_rf_b = r_regs[w_srcB];
    end

    // Operand A forwarding: youngest producer wins; "none" never matches.
    always_comb begin
        w_fwd_a = w_rf_a;
        if (w_srcA != REG_NONE) begin
            if (w_srcA == e_dstE)      w_fwd_a = e_valE;
            else if (w_srcA == M_dstM) w_fwd_a = m_valM;
            else if (w_srcA == M_dstE) w_fwd_a = M_valE;
            else if (w_srcA == W_dstM) w_fwd_a = W_valM;
            else if (w_srcA == W_dstE) w_fwd_a = W_valE;
            else                       w_fwd_a = w_rf_a;
        end
    end

    // Operand B forwarding: same priority chain as operand A.
    always_comb begin
        w_fwd_b = w_rf_b;
        if (w_srcB != REG_NONE) begin
            if (w_srcB == e_dstE)      w_fwd_b = e_valE;
            else if (w_srcB == M_dstM) w_fwd_b = m_valM;
            else if (w_srcB == M_dstE) w_fwd_b = M_valE;
            else if (w_srcB == W_dstM) w_fwd_b = W_valM;
            else if (w_srcB == W_dstE) w_fwd_b = W_valE;
            else                       w_fwd_b = w_rf_b;
        end
    end

    // call and jXX carry the return/fall-through address in valA.
    assign w_valA = ((D_icode == 4'h7) || (D_icode == 4'h8)) ? D_valP : w_fwd_a;

    // Register-file writeback; port M is written last so it wins a tie.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 15; i++) begin
                r_regs[i] <= 64'd0;
            end
        end else begin
            if (W_dstE != REG_NONE) r_regs[W_dstE] <= W_valE;
            if (W_dstM != REG_NONE) r_regs[W_dstM] <= W_valM;
        end
    end

    // Execute pipeline register: bubble on reset or request, else load decode.
    always_ff @(posedge clk) begin
        if (reset || E_bubble) begin
            E_icode <= I_NOP;
            E_ifun  <= 4'h0;
            E_stat  <= STAT_AOK;
            E_valC  <= 64'd0;
            E_valA  <= 64'd0;
            E_valB  <= 64'd0;
            E_dstE  <= REG_NONE;
            E_dstM  <= REG_NONE;
        end else begin
            E_icode <= D_icode;
            E_ifun  <= D_ifun;
            E_stat  <= D_stat;
            E_valC  <= D_valC;
            E_valA  <= w_valA;
            E_valB  <= w_fwd_b;
            E_dstE  <= w_dstE;
            E_dstM  <= w_dstM;
        end
    end

endmodule

// File: doc/decode_stage.md
DECODE_STAGE -- requirements
Module: decode_stage

Interface
REQ-001 clk  input  1  sole clock; all state updates on posedge clk.
REQ-002 reset  input  1  synchronous, active-high reset; sampled on posedge clk.
REQ-003 D_icode  input  4  decode-register instruction code.
REQ-004 D_ifun  input  4  decode-register function code.
REQ-005 D_stat  input  4  decode-register status (1 AOK, 2 HLT, 3 ADR, 4 INS).
REQ-006 D_rA  input  4  register A specifier; 4'hF = none.
REQ-007 D_rB  input  4  register B specifier; 4'hF = none.
REQ-008 D_valC  input  64  constant word.
REQ-009 D_valP  input  64  incremented PC.
REQ-010 e_dstE  input  4  execute-stage destination E (combinational).
REQ-011 e_valE  input  64  execute-stage ALU result.
REQ-012 M_dstM  input  4  memory-register destination M.
REQ-013 m_valM  input  64  memory-stage read data.
REQ-014 M_dstE  input  4  memory-register destination E.
REQ-015 M_valE  input  64  memory-register valE.
REQ-016 W_dstM  input  4  writeback destination M; also register-file write port M.
REQ-017 W_valM  input  64  writeback valM.
REQ-018 W_dstE  input  4  writeback destination E; also register-file write port E.
REQ-019 W_valE  input  64  writeback valE.
REQ-020 E_bubble  input  1  load a bubble into the execute register instead of the decoded instruction.
REQ-021 d_srcA  output  4  combinational source A, for the hazard unit.
REQ-022 d_srcB  output  4  combinational source B, for the hazard unit.
REQ-023 E_icode, E_ifun, E_stat  output  4 each  registered execute-stage codes.
REQ-024 E_valC  output  64  registered constant.
REQ-025 E_valA  output  64  registered forwarded operand A.
REQ-026 E_valB  output  64  registered forwarded operand B.
REQ-027 E_dstE, E_dstM  output  4 each  registered destinations.

Function
REQ-028 Register file: 15 x 64-bit registers, indices 0-14; reads are combinational; index F reads 0.
REQ-029 Write timing: on posedge, write W_valE to W_dstE, then W_valM to W_dstM; dstM wins if both name the same register; a destination of F suppresses the write.
REQ-030 d_srcA: rA for icode 2,4,6,A; 4 (%rsp) for icode 9,B; otherwise F.
REQ-031 d_srcB: rB for icode 4,5,6; 4 for icode 8,9,A,B; otherwise F.
REQ-032 d_dstE: rB for icode 2,3,6; 4 for icode 8,9,A,B; otherwise F.
REQ-033 d_dstM: rA for icode 5,B; otherwise F.
REQ-034 valA source: D_valP when icode is 7 or 8; otherwise forwarded from d_srcA.
REQ-035 Forwarding priority: e_dstE/e_valE, then M_dstM/m_valM, then M_dstE/M_valE, then W_dstM/W_valM, then W_dstE/W_valE, then the register file.
REQ-036 Forwarding never matches when the source is F.
REQ-037 valB: the same priority chain as valA, applied to d_srcB, with no valP override.
REQ-038 Execute register, posedge, reset=0, E_bubble=0: load icode, ifun, stat, valC, valA, valB, dstE, dstM.
REQ-039 Execute register, posedge, E_bubble=1: load icode 1, ifun 0, stat 1, dstE=dstM=F, valA=valB=valC=0.
REQ-040 Latency: the decoded instruction appears on the E_* outputs exactly 1 cycle after it is presented on the D_* inputs.

Reset
REQ-041 reset=1 at a posedge: all 15 registers become 0 and the execute register takes the REQ-039 bubble values; reset has priority over E_bubble and over W writes.
REQ-042 Reset asserted mid-stream discards the in-flight decode; the first instruction after deassertion is decoded normally.

Verification
REQ-043 Reset, then D: icode 3, rB 2, valC 0x10 -> next cycle E_icode 3, E_dstE 2, E_valC 0x10, E_dstM F.
REQ-044 W_dstE 3, W_valE 0xAA for one cycle; then D: icode 6, rA 3, rB F -> E_valA 0xAA.
REQ-045 e_dstE=M_dstE=W_dstE=1 with values 5, 6, 7; D: icode 2, rA 1 -> E_valA 5.
REQ-046 D: icode 8, valP 0x40, M_dstE 4, M_valE 0x100 -> E_valA 0x40, E_valB 0x100, E_dstE 4.
REQ-047 E_bubble=1 with a valid D instruction -> E_icode 1, E_stat 1, E_dstE F; the register file is unchanged.
REQ-048 W_dstE = W_dstM = 5, W_valE 1, W_valM 2 -> register 5 reads 2; reset together with the W write -> register 5 reads 0.
